// File: rtl/ifid_queue.sv
// In-order IF->ID instruction queue (DEPTH entries) with restart-PC tracking across delay slots.
// Latency: a pushed entry reaches the id_* outputs one CLK edge later; there is no IF->ID combinational path.
// Backpressure: if_ready drops while the queue is full; id_stall holds the head; the flushes discard entries.
module ifid_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [DATA_W-1:0]          if_instruction,
  input  logic [ADDR_W-1:0]          if_pcadd4,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic                       if_isbds,
  input  logic                       flush,
  input  logic                       exception_flush,
  input  logic                       id_stall,
  output logic                       id_valid,
  output logic [DATA_W-1:0]          id_instruction,
  output logic [ADDR_W-1:0]          id_pcadd4,
  output logic                       id_isbds,
  output logic [ADDR_W-1:0]          id_restartpc,
  output logic                       id_isflushed,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_W-1:0] mem_instr  [DEPTH];
  logic [ADDR_W-1:0] mem_pcadd4 [DEPTH];
  logic [ADDR_W-1:0] mem_rpc    [DEPTH];
  logic [DEPTH-1:0]  mem_isbds;

  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] last_restart;
  logic [ADDR_W-1:0] hold_pcadd4, hold_rpc;
  logic              have_head, push, pop;
  logic [ADDR_W-1:0] push_rpc;

  assign have_head = (count != '0);
  // Ready comes from the count register only, so a stall never ripples back into fetch in the same cycle.
  assign if_ready  = (count < FULL);
  assign push      = if_valid & if_ready & ~flush & ~exception_flush;
  assign pop       = have_head & ~id_stall;
  // A delay slot restarts at its branch, i.e. the restart PC of whatever was pushed just before it.
  assign push_rpc  = if_isbds ? last_restart : if_pc;

  // Payload storage; contents are only meaningful between the pointers, so no reset is needed here.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_instr[wr_ptr]  <= if_instruction;
      mem_pcadd4[wr_ptr] <= if_pcadd4;
      mem_rpc[wr_ptr]    <= push_rpc;
      mem_isbds[wr_ptr]  <= if_isbds;
    end
  end

  // Pointer, occupancy, restart tracking and the held head values shown while empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      last_restart <= '0;
      hold_pcadd4  <= '0;
      hold_rpc     <= '0;
    end else begin
      if (push) begin
        last_restart <= push_rpc;
      end
      // Whenever the head leaves (popped or killed), remember its PCs for the empty view.
      if ((pop || exception_flush) && have_head) begin
        hold_pcadd4 <= mem_pcadd4[rd_ptr];
        hold_rpc    <= mem_rpc[rd_ptr];
      end
      if (exception_flush) begin
        wr_ptr <= rd_ptr;
        count  <= '0;
      end else if (flush) begin
        // Keep only the branch sitting in ID, unless it leaves this very cycle.
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
          wr_ptr <= rd_ptr + PW'(1);
          count  <= '0;
        end else begin
          wr_ptr <= rd_ptr + PW'(have_head);
          count  <= CW'(have_head);
        end
      end else begin
        rd_ptr <= rd_ptr + PW'(pop);
        wr_ptr <= wr_ptr + PW'(push);
        count  <= count + CW'(push) - CW'(pop);
      end
    end
  end

  assign id_valid       = have_head;
  assign id_isflushed   = ~have_head;
  assign id_instruction = have_head ? mem_instr[rd_ptr] : '0;
  assign id_isbds       = have_head & mem_isbds[rd_ptr];
  assign id_pcadd4      = have_head ? mem_pcadd4[rd_ptr] : hold_pcadd4;
  assign id_restartpc   = have_head ? mem_rpc[rd_ptr] : hold_rpc;

endmodule

// File: tb/tb_ifid_queue.sv
module tb_ifid_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready, if_isbds;
  logic [31:0] if_instruction, if_pcadd4, if_pc;
  logic        flush, exception_flush, id_stall;
  logic        id_valid, id_isbds, id_isflushed;
  logic [31:0] id_instruction, id_pcadd4, id_restartpc;
  logic [1:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcadd4;
    logic [31:0] rpc;
    logic        isbds;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_last, m_hold_pa, m_hold_rpc;

  ifid_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instruction(if_instruction),
    .if_pcadd4(if_pcadd4), .if_pc(if_pc), .if_isbds(if_isbds),
    .flush(flush), .exception_flush(exception_flush), .id_stall(id_stall),
    .id_valid(id_valid), .id_instruction(id_instruction), .id_pcadd4(id_pcadd4),
    .id_isbds(id_isbds), .id_restartpc(id_restartpc), .id_isflushed(id_isflushed),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic bds, input logic fl, input logic ex, input logic st,
                       input logic r);
    if_valid        = v;
    if_instruction  = instr;
    if_pc           = pc;
    if_pcadd4       = pc + 32'd4;
    if_isbds        = bds;
    flush           = fl;
    exception_flush = ex;
    id_stall        = st;
    rst             = r;
  endtask

  // Queue-level reference: what the queue holds after this edge given the current inputs.
  task automatic model_step();
    int   n;
    logic ps, pp;
    ent_t e;
    if (rst) begin
      q.delete();
      m_last = '0; m_hold_pa = '0; m_hold_rpc = '0;
      return;
    end
    n  = q.size();
    ps = if_valid && (n < DEPTH) && !flush && !exception_flush;
    pp = (n > 0) && !id_stall;
    e.instr  = if_instruction;
    e.pcadd4 = if_pcadd4;
    e.isbds  = if_isbds;
    e.rpc    = if_isbds ? m_last : if_pc;
    if (exception_flush) begin
      if (n > 0) begin m_hold_pa = q[0].pcadd4; m_hold_rpc = q[0].rpc; end
      q.delete();
    end else begin
      if (pp) begin
        m_hold_pa = q[0].pcadd4; m_hold_rpc = q[0].rpc;
        void'(q.pop_front());
      end
      if (flush) begin
        if (pp) q.delete();
        else while (q.size() > 1) void'(q.pop_back());
      end
      if (ps) q.push_back(e);
    end
    if (ps) m_last = e.rpc;
  endtask

  task automatic check_all(input string tag);
    logic h;
    h = (q.size() > 0);
    chk({tag, ".count"},    64'(count),          64'(q.size()));
    chk({tag, ".if_ready"}, 64'(if_ready),       64'(q.size() < DEPTH));
    chk({tag, ".valid"},    64'(id_valid),       64'(h));
    chk({tag, ".flushed"},  64'(id_isflushed),   64'(!h));
    chk({tag, ".instr"},    64'(id_instruction), h ? 64'(q[0].instr) : 64'd0);
    chk({tag, ".isbds"},    64'(id_isbds),       h ? 64'(q[0].isbds) : 64'd0);
    chk({tag, ".pcadd4"},   64'(id_pcadd4),      h ? 64'(q[0].pcadd4) : 64'(m_hold_pa));
    chk({tag, ".rpc"},      64'(id_restartpc),   h ? 64'(q[0].rpc) : 64'(m_hold_rpc));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    // Reset
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    cycle("rst");
    chk("rst.count_const", 64'(count), 64'd0);
    chk("rst.ready_const", 64'(if_ready), 64'd1);

    // Single push, pass-through with no stall
    drive(1, 32'h8C010000, 32'h100, 0, 0, 0, 0, 0);
    cycle("t1a");
    chk("t1.instr_const", 64'(id_instruction), 64'h8C010000);
    chk("t1.rpc_const",   64'(id_restartpc),   64'h100);
    chk("t1.flushed0",    64'(id_isflushed),   64'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("t1b");
    chk("t1.empty_flushed", 64'(id_isflushed), 64'd1);
    chk("t1.hold_pcadd4",   64'(id_pcadd4),    64'h104);

    // Fill under stall, third push refused, then drain
    drive(1, 32'hAA000110, 32'h110, 0, 0, 0, 1, 0); cycle("t2a");
    drive(1, 32'hAA000114, 32'h114, 0, 0, 0, 1, 0); cycle("t2b");
    chk("t2.full_ready", 64'(if_ready), 64'd0);
    drive(1, 32'hAA000118, 32'h118, 0, 0, 0, 1, 0); cycle("t2c");
    chk("t2.sat_count", 64'(count), 64'd2);
    drive(0, 0, 0, 0, 0, 0, 0, 0); cycle("t2d");
    chk("t2.second", 64'(id_instruction), 64'hAA000114);
    cycle("t2e");

    // Branch then delay slot
    drive(1, 32'hAA000200, 32'h200, 0, 0, 0, 0, 0); cycle("t3a");
    drive(1, 32'hAA000204, 32'h204, 1, 0, 0, 0, 0); cycle("t3b");
    chk("t3.isbds", 64'(id_isbds), 64'd1);
    chk("t3.rpc",   64'(id_restartpc), 64'h200);
    drive(0, 0, 0, 0, 0, 0, 0, 0); cycle("t3c");

    // Flush with branch held in ID
    drive(1, 32'hAA000300, 32'h300, 0, 0, 0, 1, 0); cycle("t4a");
    drive(1, 32'hAA000304, 32'h304, 1, 0, 0, 1, 0); cycle("t4b");
    drive(1, 32'hAA000308, 32'h308, 0, 1, 0, 1, 0); cycle("t4c");
    chk("t4.count1", 64'(count), 64'd1);
    chk("t4.branch", 64'(id_instruction), 64'hAA000300);
    drive(0, 0, 0, 0, 0, 0, 0, 0); cycle("t4d");
    chk("t4.flushed", 64'(id_isflushed), 64'd1);

    // Exception flush overrides stall and incoming entry
    drive(1, 32'hAA000400, 32'h400, 0, 0, 0, 1, 0); cycle("t5a");
    drive(1, 32'hAA000404, 32'h404, 0, 0, 0, 1, 0); cycle("t5b");
    drive(1, 32'hAA000408, 32'h408, 0, 0, 1, 1, 0); cycle("t5c");
    chk("t5.count0", 64'(count), 64'd0);
    chk("t5.instr0", 64'(id_instruction), 64'd0);

    // Reset mid-stream with a full queue
    drive(1, 32'hAA000500, 32'h500, 0, 0, 0, 1, 0); cycle("t6a");
    drive(1, 32'hAA000504, 32'h504, 0, 0, 0, 1, 0); cycle("t6b");
    drive(1, 32'hAA000508, 32'h508, 0, 0, 0, 1, 1); cycle("t6c");
    chk("t6.ready", 64'(if_ready), 64'd1);
    chk("t6.rpc0",  64'(id_restartpc), 64'd0);

    // Randomized traffic against the reference
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 2) != 0, $urandom, {$urandom_range(0, 16'hFFFF), 2'b00},
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 99) == 0);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
